// File: rtl/arb_req_stage.sv
// Stages one payload per port, pulses req_o to the fixed-priority arbiter and moves the granted payload to a valid/ready output.
// Three-cycle accept-to-out_valid_o latency; the output holds until out_ready_i, and `ifdef ARB_STAGE_ERR_EN adds sticky err_o.
module arb_req_stage #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          in_valid_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data_i,
    output logic [NUM_PORTS-1:0]          in_ready_o,
    output logic [NUM_PORTS-1:0]          req_o,
    input  logic [NUM_PORTS-1:0]          gnt_i,
    output logic                          out_valid_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [PORT_W-1:0]             out_port_o,
`ifdef ARB_STAGE_ERR_EN
    output logic                          err_o,
`endif
    input  logic                          out_ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_OUT} state_t;

    state_t                 r_state;
    logic [NUM_PORTS-1:0]   r_pend;
    logic [DATA_W-1:0]      r_hold [NUM_PORTS];
    logic [NUM_PORTS-1:0]   r_req;
    logic                   r_out_vld;
    logic [DATA_W-1:0]      r_out_dat;
    logic [PORT_W-1:0]      r_out_port;

    logic [NUM_PORTS-1:0]   w_accept;
    logic [NUM_PORTS-1:0]   w_hit;
    logic                   w_hit_any;
    logic [PORT_W-1:0]      w_sel;
    logic [NUM_PORTS-1:0]   w_pend_clr;

    assign w_accept  = in_valid_i & ~r_pend;
    assign w_hit     = gnt_i & r_pend;
    assign w_hit_any = |w_hit;

    // Descending scan so the lowest pending granted index wins on a multi-hot grant.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel = PORT_W'(i);
            end
        end
    end

    assign w_pend_clr = (r_state == S_CAPT && w_hit_any) ? (NUM_PORTS'(1) << w_sel) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_req      <= '0;
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_port <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_accept[i]) begin
                    r_hold[i] <= in_data_i[i*DATA_W +: DATA_W];
                end
            end
            r_pend <= (r_pend & ~w_pend_clr) | w_accept;

            case (r_state)
                S_IDLE: begin
                    if (|r_pend) begin
                        r_req   <= r_pend;
                        r_state <= S_WAIT;
                    end else begin
                        r_req   <= '0;
                    end
                end
                S_WAIT: begin
                    r_req   <= '0;
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    if (w_hit_any) begin
                        r_out_dat  <= r_hold[w_sel];
                        r_out_port <= w_sel;
                        r_out_vld  <= 1'b1;
                        r_state    <= S_OUT;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_OUT: begin
                    // Re-request straight from the handshake edge to keep one transfer per 3 cycles.
                    if (out_ready_i) begin
                        r_out_vld <= 1'b0;
                        if (|r_pend) begin
                            r_req   <= r_pend;
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_STAGE_ERR_EN
    logic r_err;
    logic w_gnt_bad;

    assign w_gnt_bad = (gnt_i == '0)
                     || ((gnt_i & (gnt_i - NUM_PORTS'(1))) != '0)
                     || ((gnt_i & ~r_pend) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == S_CAPT && w_gnt_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

    assign in_ready_o  = ~r_pend;
    assign req_o       = r_req;
    assign out_valid_o = r_out_vld;
    assign out_data_o  = r_out_dat;
    assign out_port_o  = r_out_port;

endmodule

// File: tb/tb_arb_req_stage.sv
// Bench for arb_req_stage with a registered fixed-priority arbiter model closing the req/gnt loop.
module tb_arb_req_stage;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     in_valid;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_ready;
    logic [NP-1:0]     req;
    logic [NP-1:0]     gnt;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [PW-1:0]     out_port;
    logic              out_ready;
    logic              force_zero;
`ifdef ARB_STAGE_ERR_EN
    logic              err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_req_stage #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .req_o       (req),
        .gnt_i       (gnt),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_port_o  (out_port),
`ifdef ARB_STAGE_ERR_EN
        .err_o       (err),
`endif
        .out_ready_i (out_ready)
    );

    // Registered fixed-priority arbiter: lowest requesting index wins.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gnt <= '0;
        else        gnt <= force_zero ? '0 : (req & (~req + 4'd1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1; force_zero = 1'b0;
        #3;
        checks++;
        if ({out_valid, out_port, out_data, req, in_ready} !== {1'b0, 2'd0, 8'h00, 4'h0, 4'hF}) begin
            errors++;
            $display("FAIL reset_state: got v=%0b p=%0d d=%h req=%b rdy=%b, expected 0/0/00/0000/1111",
                     out_valid, out_port, out_data, req, in_ready);
        end
`ifdef ARB_STAGE_ERR_EN
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 4'b0100; in_data = 32'h005A0000;
        step();
        in_valid = '0;
        checks++;
        if ({in_ready, req} !== {4'b1011, 4'b0000}) begin
            errors++; $display("FAIL single_accept: rdy=%b req=%b expected 1011/0000", in_ready, req);
        end
        step();
        checks++;
        if ({req, out_valid} !== {4'b0100, 1'b0}) begin
            errors++; $display("FAIL single_req: req=%b v=%b expected 0100/0", req, out_valid);
        end
        step();
        checks++;
        if ({req, out_valid} !== {4'b0000, 1'b0}) begin
            errors++; $display("FAIL single_req_pulse: req=%b v=%b expected 0000/0", req, out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_data, out_port} !== {1'b1, 8'h5A, 2'd2}) begin
            errors++; $display("FAIL single_out: v=%b d=%h p=%0d expected 1/5a/2", out_valid, out_data, out_port);
        end
        step();
        checks++;
        if ({out_valid, in_ready, req} !== {1'b0, 4'hF, 4'h0}) begin
            errors++; $display("FAIL single_done: v=%b rdy=%b req=%b expected 0/1111/0000", out_valid, in_ready, req);
        end
    endtask

    task automatic test_all_ports();
        out_ready = 1'b1;
        in_valid = 4'hF; in_data = 32'h13121110;
        step();
        in_valid = '0;
        for (int k = 0; k < NP; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL all_gap_a[%0d]: v=%b expected 0", k, out_valid); end
            if (k > 0) begin
                checks++;
                if (req !== (4'hF & ~4'((1 << k) - 1))) begin
                    errors++; $display("FAIL all_req[%0d]: req=%b expected %b", k, req, 4'hF & ~4'((1 << k) - 1));
                end
            end
            step();
            step();
            checks++;
            if ({out_valid, out_data, out_port, in_ready} !== {1'b1, 8'(8'h10 + k), 2'(k), 4'((1 << (k + 1)) - 1)}) begin
                errors++;
                $display("FAIL all_out[%0d]: v=%b d=%h p=%0d rdy=%b expected 1/%h/%0d/%b", k, out_valid, out_data,
                         out_port, in_ready, 8'(8'h10 + k), k, 4'((1 << (k + 1)) - 1));
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 4'b0011; in_data = 32'h00004433;
        step();
        in_valid = '0;
        step(); step(); step();
        checks++;
        if ({out_valid, out_data, out_port} !== {1'b1, 8'h33, 2'd0}) begin
            errors++; $display("FAIL bp_first: v=%b d=%h p=%0d expected 1/33/0", out_valid, out_data, out_port);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({out_valid, out_data, out_port, req} !== {1'b1, 8'h33, 2'd0, 4'h0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: v=%b d=%h p=%0d req=%b expected 1/33/0/0000", c, out_valid, out_data, out_port, req);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, req} !== {1'b0, 4'b0010}) begin
            errors++; $display("FAIL bp_release: v=%b req=%b expected 0/0010", out_valid, req);
        end
        step(); step();
        checks++;
        if ({out_valid, out_data, out_port} !== {1'b1, 8'h44, 2'd1}) begin
            errors++; $display("FAIL bp_second: v=%b d=%h p=%0d expected 1/44/1", out_valid, out_data, out_port);
        end
        step();
    endtask

    task automatic test_bad_grant();
        out_ready = 1'b1; force_zero = 1'b1;
        in_valid = 4'b0010; in_data = 32'h00009900;
        step();
        in_valid = '0;
        step();
        checks++;
        if (req !== 4'b0010) begin errors++; $display("FAIL bad_req1: req=%b expected 0010", req); end
        step();
        step();
        checks++;
        if ({out_valid, in_ready, req} !== {1'b0, 4'b1101, 4'h0}) begin
            errors++; $display("FAIL bad_nogrant: v=%b rdy=%b req=%b expected 0/1101/0000", out_valid, in_ready, req);
        end
`ifdef ARB_STAGE_ERR_EN
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b expected 1", err); end
`endif
        step();
        checks++;
        if (req !== 4'b0010) begin errors++; $display("FAIL bad_req2: req=%b expected 0010", req); end
        force_zero = 1'b0;
        step();
        step();
        checks++;
        if ({out_valid, out_data, out_port, in_ready} !== {1'b1, 8'h99, 2'd1, 4'hF}) begin
            errors++;
            $display("FAIL bad_retry_out: v=%b d=%h p=%0d rdy=%b expected 1/99/1/1111", out_valid, out_data, out_port, in_ready);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 4'b0111; in_data = 32'h00222120;
        step();
        in_valid = '0;
        step(); step(); step();
        checks++;
        if ({out_valid, out_port, in_ready} !== {1'b1, 2'd0, 4'b1001}) begin
            errors++; $display("FAIL rst_pre: v=%b p=%0d rdy=%b expected 1/0/1001", out_valid, out_port, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_port, out_data, req, in_ready} !== {1'b0, 2'd0, 8'h00, 4'h0, 4'hF}) begin
            errors++;
            $display("FAIL rst_async: v=%b p=%0d d=%h req=%b rdy=%b expected 0/0/00/0000/1111",
                     out_valid, out_port, out_data, req, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if ({out_valid, req, in_ready} !== {1'b0, 4'h0, 4'hF}) begin
                errors++; $display("FAIL rst_stale[%0d]: v=%b req=%b rdy=%b expected 0/0000/1111", c, out_valid, req, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0;
        int n_out = 0;
        int acc_cyc[2];
        logic acc, hs;
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        out_ready = 1'b1;
        in_valid = 4'b1000; in_data = 32'h77000000;
        for (int c = 0; c < 20; c++) begin
            acc = in_valid[3] & in_ready[3];
            hs  = out_valid & out_ready;
            d = out_data; p = out_port;
            step();
            if (acc) begin
                if (n_acc < 2) acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc == 1) begin
                    checks++;
                    if (in_ready[3] !== 1'b0) begin errors++; $display("FAIL b2b_block: rdy3=%b expected 0", in_ready[3]); end
                end
                if (n_acc == 2) in_valid = '0;
            end
            if (hs) begin
                n_out++;
                checks++;
                if ({d, p} !== {8'h77, 2'd3}) begin
                    errors++; $display("FAIL b2b_data: d=%h p=%0d expected 77/3", d, p);
                end
            end
        end
        checks++;
        if (n_acc != 2 || n_out != 2) begin
            errors++; $display("FAIL b2b_count: accepts=%0d outputs=%0d expected 2/2", n_acc, n_out);
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] != 4) begin
            errors++; $display("FAIL b2b_spacing: got %0d cycles expected 4", acc_cyc[1] - acc_cyc[0]);
        end
    endtask

    // Model: each port holds at most one payload until it shows up on a fresh out_valid.
    task automatic test_random();
        localparam int N = 400;
        logic [NP-1:0]    pend_m = '0;
        logic [DW-1:0]    hold_m [NP];
        logic [NP-1:0]    acc;
        logic [NP*DW-1:0] ad;
        logic             pv, pr;
        logic [DW-1:0]    pd;
        logic [PW-1:0]    pp;
        logic [NP-1:0]    preq;
        int sent = 0;
        int delivered = 0;
        for (int i = 0; i < NP; i++) hold_m[i] = '0;
        for (int c = 0; c < N; c++) begin
            if (c < N - 30) begin
                in_valid  = 4'($urandom_range(0, 15));
                in_data   = $urandom;
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = '0;
                out_ready = 1'b1;
            end
            #1;
            acc = in_valid & in_ready; ad = in_data;
            pv = out_valid; pr = out_ready; pd = out_data; pp = out_port; preq = req;
            step();
            if (out_valid && !pv) begin
                checks++;
                if (pend_m[out_port] !== 1'b1 || out_data !== hold_m[out_port]) begin
                    errors++;
                    $display("FAIL rnd_out c=%0d: p=%0d d=%h expected pending=1 d=%h", c, out_port, out_data, hold_m[out_port]);
                end
                pend_m[out_port] = 1'b0;
                delivered++;
            end
            for (int i = 0; i < NP; i++) begin
                if (acc[i]) begin
                    pend_m[i] = 1'b1;
                    hold_m[i] = ad[i*DW +: DW];
                    sent++;
                end
            end
            checks++;
            if (in_ready !== ~pend_m) begin
                errors++; $display("FAIL rnd_ready c=%0d: rdy=%b expected %b", c, in_ready, ~pend_m);
            end
            if (pv && !pr) begin
                checks++;
                if ({out_valid, out_data, out_port} !== {1'b1, pd, pp}) begin
                    errors++;
                    $display("FAIL rnd_hold c=%0d: v=%b d=%h p=%0d expected 1/%h/%0d", c, out_valid, out_data, out_port, pd, pp);
                end
            end
            if (preq != '0) begin
                checks++;
                if (req !== 4'h0) begin errors++; $display("FAIL rnd_req_pulse c=%0d: req=%b expected 0000", c, req); end
            end
        end
        checks++;
        if (pend_m != '0 || out_valid !== 1'b0 || sent != delivered) begin
            errors++;
            $display("FAIL rnd_drain: pend=%b v=%b sent=%0d delivered=%0d expected 0000/0/equal", pend_m, out_valid, sent, delivered);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_ports();
        test_backpressure();
        test_bad_grant();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
